// File: rtl/pc_sequencer.sv
// Program-counter sequencer for a core with a small circular return-address stack.
// It holds the PC and produces PC+1 as push data.
// It issues push/pop strobes for call/return.
// It waits one cycle after a pop for the stack's registered output.
// It tracks how many valid entries the stack holds and flags overflow/underflow.
module pc_sequencer #(
    parameter int                ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] stack_output,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] incr_output,
    output logic              SP_p,
    output logic              SP_n,
    output logic              Stack_EN,
    output logic              RW,
    output logic              busy,
    output logic              stack_ovf,
    output logic              stack_unf
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN,
        RET_WAIT
    } state_t;

    state_t             state;
    logic [DEPTH_W-1:0] depth;
    logic               accept;
    logic               depth_empty;
    logic               depth_full;

    assign incr_output = pc + ADDR_W'(1);
    assign depth_empty = (depth == '0);
    assign depth_full  = (depth == DEPTH_W'(DEPTH));

    // Stack strobes: only in RUN, never during stall or reset; ret outranks call.
    always_comb begin
        accept = rst_n && !stall && (state == RUN);
        SP_n   = accept && ret && !depth_empty;
        SP_p   = accept && call && !ret;
    end

    assign Stack_EN = SP_p | SP_n;
    assign RW       = SP_p;
    assign busy     = (state == RET_WAIT);

    // PC, state, depth and sticky flags; stall freezes everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_VEC;
            state     <= RUN;
            depth     <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (!stall) begin
            case (state)
                RUN: begin
                    if (ret) begin
                        if (!depth_empty) begin
                            // Pop issued now; the address arrives on stack_output next cycle.
                            depth <= depth - DEPTH_W'(1);
                            state <= RET_WAIT;
                        end else begin
                            stack_unf <= 1'b1;
                            pc        <= incr_output;
                        end
                    end else if (call) begin
                        pc <= target;
                        // At full depth the push wraps over the oldest entry.
                        // The count saturates.
                        if (depth_full) begin
                            stack_ovf <= 1'b1;
                        end else begin
                            depth <= depth + DEPTH_W'(1);
                        end
                    end else if (jump) begin
                        pc <= target;
                    end else begin
                        pc <= incr_output;
                    end
                end
                RET_WAIT: begin
                    pc    <= stack_output;
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer.
// It contains a 4-entry circular return stack with a registered pop output.
// It also contains a queue-based reference model of the call/return behaviour.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jump;
    logic        call;
    logic        ret;
    logic [13:0] target;
    logic [13:0] stack_output = '0;
    logic [13:0] pc;
    logic [13:0] incr_output;
    logic        SP_p;
    logic        SP_n;
    logic        Stack_EN;
    logic        RW;
    logic        busy;
    logic        stack_ovf;
    logic        stack_unf;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .jump        (jump),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .stack_output(stack_output),
        .pc          (pc),
        .incr_output (incr_output),
        .SP_p        (SP_p),
        .SP_n        (SP_n),
        .Stack_EN    (Stack_EN),
        .RW          (RW),
        .busy        (busy),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return stack: circular, pointer relative, not reset, registered pop output.
    logic [13:0] smem [4] = '{default: '0};
    logic [1:0]  sptr = '0;
    always @(posedge clk) begin
        if (SP_p) begin
            smem[sptr] <= incr_output;
            sptr       <= sptr + 2'd1;
        end else if (SP_n) begin
            stack_output <= smem[sptr - 2'd1];
            sptr         <= sptr - 2'd1;
        end
    end

    // Reference model: a bounded list of return addresses plus a pending-return slot.
    logic [13:0] m_pc = '0;
    logic [13:0] m_pend = '0;
    bit          m_wait = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
    logic [13:0] m_q [$];

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chka(input string nm, input logic [13:0] act, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        if (!rst_n) begin
            m_pc   = 14'h0000;
            m_wait = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_q.delete();
        end else if (stall) begin
            // everything held
        end else if (m_wait) begin
            m_pc   = m_pend;
            m_wait = 1'b0;
        end else if (ret && m_q.size() > 0) begin
            m_pend = m_q.pop_back();
            m_wait = 1'b1;
        end else if (ret) begin
            m_unf = 1'b1;
            m_pc  = m_pc + 14'd1;
        end else if (call) begin
            if (m_q.size() == 4) begin
                void'(m_q.pop_front());
                m_ovf = 1'b1;
            end
            m_q.push_back(m_pc + 14'd1);
            m_pc = target;
        end else if (jump) begin
            m_pc = target;
        end else begin
            m_pc = m_pc + 14'd1;
        end
    endfunction

    task automatic check_model();
        bit e_push;
        bit e_pop;
        e_push = rst_n && !stall && !m_wait && call && !ret;
        e_pop  = rst_n && !stall && !m_wait && ret && (m_q.size() > 0);
        chka("pc", pc, m_pc);
        chka("incr_output", incr_output, m_pc + 14'd1);
        chk1("SP_p", SP_p, e_push);
        chk1("SP_n", SP_n, e_pop);
        chk1("Stack_EN", Stack_EN, e_push | e_pop);
        chk1("RW", RW, e_push);
        chk1("busy", busy, m_wait);
        chk1("stack_ovf", stack_ovf, m_ovf);
        chk1("stack_unf", stack_unf, m_unf);
    endtask

    task automatic drive(input bit r, input bit s, input bit j, input bit c, input bit rt,
                         input logic [13:0] t);
        rst_n  = r;
        stall  = s;
        jump   = j;
        call   = c;
        ret    = rt;
        target = t;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input bit r, input bit s, input bit j, input bit c, input bit rt,
                       input logic [13:0] t);
        drive(r, s, j, c, rt, t);
        @(negedge clk);
        check_model();
        advance();
    endtask

    task automatic do_reset();
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0);
    endtask

    typedef struct {
        bit          stall;
        bit          jump;
        bit          call;
        bit          ret;
        logic [13:0] target;
        logic [13:0] e_pc;
        logic [13:0] e_incr;
        bit          e_push;
        bit          e_pop;
        bit          e_busy;
    } vec_t;

    vec_t        tbl [15];
    logic [13:0] nest_ret [4];
    logic [13:0] ovf_ret [4];

    initial begin
        tbl = '{
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000, 14'h0001, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0001, 14'h0002, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0002, 14'h0003, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0003, 14'h0004, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0004, 14'h0005, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 14'h0100, 14'h0005, 14'h0006, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0100, 14'h0101, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0101, 14'h0102, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 14'h0000, 14'h0102, 14'h0103, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0102, 14'h0103, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0006, 14'h0007, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 14'h3FFE, 14'h0007, 14'h0008, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h3FFE, 14'h3FFF, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h3FFF, 14'h0000, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000, 14'h0001, 1'b0, 1'b0, 1'b0}
        };
        nest_ret = '{14'h0031, 14'h0021, 14'h0011, 14'h0002};
        ovf_ret  = '{14'h0401, 14'h0301, 14'h0201, 14'h0101};

        // Initial reset: DUT state is unknown before it, so no checks yet.
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0);
        @(negedge clk);
        advance();
        chka("reset_pc", pc, 14'h0000);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_ovf", stack_ovf, 1'b0);
        chk1("reset_unf", stack_unf, 1'b0);

        // Directed vectors: idle counting, call/ret round trip, 14-bit wrap.
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, tbl[i].stall, tbl[i].jump, tbl[i].call, tbl[i].ret, tbl[i].target);
            @(negedge clk);
            check_model();
            chka($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
            chka($sformatf("tbl%0d_incr", i), incr_output, tbl[i].e_incr);
            chk1($sformatf("tbl%0d_push", i), SP_p, tbl[i].e_push);
            chk1($sformatf("tbl%0d_pop", i), SP_n, tbl[i].e_pop);
            chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            advance();
        end

        // Nested calls then four returns.
        do_reset();
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0);
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0010);
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0020);
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0030);
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0040);
        chka("nest_pc_deep", pc, 14'h0040);
        for (int i = 0; i < 4; i++) begin
            run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
            chk1($sformatf("nest_busy%0d", i), busy, 1'b1);
            run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0);
            chka($sformatf("nest_ret%0d", i), pc, nest_ret[i]);
        end
        chk1("nest_ovf", stack_ovf, 1'b0);
        chk1("nest_unf", stack_unf, 1'b0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
        chk1("nest_empty_unf", stack_unf, 1'b1);

        // Five calls overflow a 4-deep stack; the oldest return is lost.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'(k * 256));
            if (k == 4) chk1("ovf_after4", stack_ovf, 1'b0);
        end
        chk1("ovf_after5", stack_ovf, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
            run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0);
            chka($sformatf("ovf_ret%0d", i), pc, ovf_ret[i]);
        end
        chk1("ovf_unf_before", stack_unf, 1'b0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
        chk1("ovf_unf_after", stack_unf, 1'b1);
        chka("ovf_unf_pc", pc, 14'h0102);

        // ret and call together: ret wins. Then stall through RET_WAIT.
        do_reset();
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0050);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0077);
        @(negedge clk);
        check_model();
        chk1("prio_pop", SP_n, 1'b1);
        chk1("prio_push", SP_p, 1'b0);
        advance();
        chka("prio_pc_held", pc, 14'h0050);
        chk1("prio_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            run(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 14'h0123);
            chka($sformatf("stall_pc%0d", i), pc, 14'h0050);
            chk1($sformatf("stall_busy%0d", i), busy, 1'b1);
        end
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0);
        chka("stall_release_pc", pc, 14'h0001);
        chk1("stall_release_busy", busy, 1'b0);

        // Reset during RET_WAIT discards the pending return and zeroes depth.
        do_reset();
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0060);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
        chk1("rstw_busy_before", busy, 1'b1);
        do_reset();
        chka("rstw_pc", pc, 14'h0000);
        chk1("rstw_busy", busy, 1'b0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
        chk1("rstw_depth0_unf", stack_unf, 1'b1);
        chka("rstw_depth0_pc", pc, 14'h0001);
        run(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0070);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0);
        chka("rstw_roundtrip", pc, 14'h0002);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit          rr;
            bit          ss;
            bit          jj;
            bit          cc;
            bit          rt;
            logic [13:0] tt;
            rr = ($urandom_range(0, 63) != 0);
            ss = ($urandom_range(0, 4) == 0);
            jj = ($urandom_range(0, 5) == 0);
            cc = ($urandom_range(0, 3) == 0);
            rt = ($urandom_range(0, 3) == 0);
            tt = 14'($urandom);
            run(rr, ss, jj, cc, rt, tt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
